// File: rtl/memory_access_stage.sv
// MEM stage of the pipelined MIPS core: issues data-memory accesses over a req/ack handshake,
// stalls while an access is outstanding, and holds the MEM/WB pipeline register.
module memory_access_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WRITEREG_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ValidM,
    input  logic                      RegWriteM,
    input  logic                      MemtoRegM,
    input  logic                      MemWriteM,
    input  logic [DATA_WIDTH-1:0]     ALUOutM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    input  logic [WRITEREG_WIDTH-1:0] WriteRegM,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      StallM,
    output logic                      RegWriteW,
    output logic                      MemtoRegW,
    output logic [DATA_WIDTH-1:0]     ALUOutW,
    output logic [DATA_WIDTH-1:0]     ReadDataW,
    output logic [WRITEREG_WIDTH-1:0] WriteRegW,
    output logic                      MemErrW
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      reg_write_q, reg_write_d;
    logic                      memto_reg_q, memto_reg_d;
    logic [DATA_WIDTH-1:0]     alu_out_q, alu_out_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
    logic [WRITEREG_WIDTH-1:0] write_reg_q, write_reg_d;
    logic                      mem_err_q, mem_err_d;

    logic memop, aligned, complete, abort, misaligned;

    assign memop   = ValidM & (MemtoRegM | MemWriteM) & ~rst;
    assign aligned = (ALUOutM[1:0] == 2'b00);

    // Upstream holds the *M inputs while stalled, so the request fields stay constant.
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dmem_req   = 1'b0;
        StallM     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        misaligned = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (memop && aligned) begin
                        dmem_req = 1'b1;
                        if (dmem_ack) begin
                            complete = 1'b1;
                        end else begin
                            StallM  = 1'b1;
                            state_d = StWait;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (memop) begin
                        misaligned = 1'b1;
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        dmem_req = 1'b1;
                        complete = 1'b1;
                        state_d  = StIdle;
                        cnt_d    = '0;
                    end else if (cnt_q == CntLimit) begin
                        // Request drops in the abort cycle so a late ack cannot complete it.
                        abort   = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        dmem_req = 1'b1;
                        StallM   = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        reg_write_d = reg_write_q;
        memto_reg_d = memto_reg_q;
        alu_out_d   = alu_out_q;
        read_data_d = read_data_q;
        write_reg_d = write_reg_q;
        mem_err_d   = mem_err_q;
        if (StallM) begin
            reg_write_d = 1'b0;
            mem_err_d   = 1'b0;
        end else if (misaligned || abort) begin
            reg_write_d = 1'b0;
            mem_err_d   = 1'b1;
        end else begin
            reg_write_d = RegWriteM & ValidM;
            memto_reg_d = MemtoRegM;
            alu_out_d   = ALUOutM;
            write_reg_d = WriteRegM;
            mem_err_d   = 1'b0;
            if (complete && MemtoRegM) begin
                read_data_d = dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            alu_out_q   <= '0;
            read_data_q <= '0;
            write_reg_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            memto_reg_q <= memto_reg_d;
            alu_out_q   <= alu_out_d;
            read_data_q <= read_data_d;
            write_reg_q <= write_reg_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign RegWriteW = reg_write_q;
    assign MemtoRegW = memto_reg_q;
    assign ALUOutW   = alu_out_q;
    assign ReadDataW = read_data_q;
    assign WriteRegW = write_reg_q;
    assign MemErrW   = mem_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: table of single-cycle vectors plus hand-written multi-cycle
// sequences; expected writeback records are queued when driven and compared a cycle later.
module tb_memory_access_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned WW = 5;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ValidM, RegWriteM, MemtoRegM, MemWriteM;
    logic [DW-1:0] ALUOutM, WriteDataM;
    logic [WW-1:0] WriteRegM;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic          StallM;
    logic          RegWriteW, MemtoRegW, MemErrW;
    logic [DW-1:0] ALUOutW, ReadDataW;
    logic [WW-1:0] WriteRegW;

    always #5 clk = ~clk;

    memory_access_stage #(
        .DATA_WIDTH    (DW),
        .WRITEREG_WIDTH(WW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ValidM    (ValidM),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .WriteRegM (WriteRegM),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ack  (dmem_ack),
        .StallM    (StallM),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ALUOutW   (ALUOutW),
        .ReadDataW (ReadDataW),
        .WriteRegW (WriteRegW),
        .MemErrW   (MemErrW)
    );

    typedef struct {
        logic          rw, m2r, err;
        logic [31:0]   alu, rd;
        logic [4:0]    wr;
        bit            full;
    } wexp_t;

    typedef struct {
        logic          r, v, rw, m2r, mw;
        logic [31:0]   alu, wd;
        logic [4:0]    wr;
        logic          ack;
        logic [31:0]   rdata;
        logic          e_req, e_stall;
        wexp_t         w;
    } vec_t;

    wexp_t sb[$];
    int    errors = 0;
    int    checks = 0;
    vec_t  tbl[10];

    function automatic wexp_t wf(logic rw, logic m2r, logic [31:0] alu, logic [31:0] rd,
                                 logic [4:0] wr);
        wexp_t e;
        e.rw = rw; e.m2r = m2r; e.alu = alu; e.rd = rd; e.wr = wr; e.err = 1'b0; e.full = 1'b1;
        return e;
    endfunction

    // Bubble or error record: only RegWriteW and MemErrW are defined.
    function automatic wexp_t wp(logic err);
        wexp_t e;
        e.rw = 1'b0; e.m2r = 1'b0; e.alu = '0; e.rd = '0; e.wr = '0; e.err = err; e.full = 1'b0;
        return e;
    endfunction

    function automatic vec_t mk(logic r, logic v, logic rw, logic m2r, logic mw,
                                logic [31:0] alu, logic [31:0] wd, logic [4:0] wr,
                                logic ack, logic [31:0] rdata, logic e_req, logic e_stall,
                                wexp_t w);
        vec_t t;
        t.r = r; t.v = v; t.rw = rw; t.m2r = m2r; t.mw = mw; t.alu = alu; t.wd = wd; t.wr = wr;
        t.ack = ack; t.rdata = rdata; t.e_req = e_req; t.e_stall = e_stall; t.w = w;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check();
        wexp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
            chk("MemErrW", 32'(MemErrW), 32'(e.err));
            if (e.full) begin
                chk("MemtoRegW", 32'(MemtoRegW), 32'(e.m2r));
                chk("ALUOutW", ALUOutW, e.alu);
                chk("ReadDataW", ReadDataW, e.rd);
                chk("WriteRegW", 32'(WriteRegW), 32'(e.wr));
            end
        end
    endtask

    // One clock: compare last cycle's W outputs, apply inputs, check combinational handshake.
    task automatic step(input vec_t t);
        @(negedge clk);
        pop_check();
        rst = t.r; ValidM = t.v; RegWriteM = t.rw; MemtoRegM = t.m2r; MemWriteM = t.mw;
        ALUOutM = t.alu; WriteDataM = t.wd; WriteRegM = t.wr;
        dmem_ack = t.ack; dmem_rdata = t.rdata;
        #1;
        chk("dmem_req", 32'(dmem_req), 32'(t.e_req));
        chk("StallM", 32'(StallM), 32'(t.e_stall));
        if (t.e_req) begin
            chk("dmem_we", 32'(dmem_we), 32'(t.mw));
            chk("dmem_addr", dmem_addr, t.alu);
            chk("dmem_wdata", dmem_wdata, t.wd);
        end
        sb.push_back(t.w);
    endtask

    initial begin
        vec_t nop;
        rst = 1'b1; ValidM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        ALUOutM = '0; WriteDataM = '0; WriteRegM = '0; dmem_ack = 1'b0; dmem_rdata = '0;

        tbl[0] = mk(0, 1, 1, 1, 0, 32'h100, 0, 5, 1, 32'hDEADBEEF, 1, 0,
                    wf(1, 1, 32'h100, 32'hDEADBEEF, 5));
        tbl[1] = mk(0, 1, 1, 0, 0, 32'h7, 0, 3, 0, 0, 0, 0, wf(1, 0, 32'h7, 32'hDEADBEEF, 3));
        tbl[2] = mk(0, 0, 1, 0, 0, 32'h7, 0, 3, 0, 0, 0, 0, wf(0, 0, 32'h7, 32'hDEADBEEF, 3));
        tbl[3] = mk(0, 1, 1, 1, 0, 32'h103, 0, 4, 1, 32'hBAD, 0, 0, wp(1));
        tbl[4] = mk(0, 1, 1, 0, 0, 32'h55, 0, 9, 0, 0, 0, 0, wf(1, 0, 32'h55, 32'hDEADBEEF, 9));
        tbl[5] = mk(0, 1, 0, 0, 1, 32'h200, 32'hA5A5, 0, 1, 32'h999, 1, 0,
                    wf(0, 0, 32'h200, 32'hDEADBEEF, 0));
        tbl[6] = mk(0, 1, 1, 1, 0, 32'h204, 0, 31, 1, 32'hCAFEF00D, 1, 0,
                    wf(1, 1, 32'h204, 32'hCAFEF00D, 31));
        tbl[7] = mk(0, 1, 1, 0, 0, 32'h10, 0, 2, 1, 32'h1111, 0, 0,
                    wf(1, 0, 32'h10, 32'hCAFEF00D, 2));
        tbl[8] = mk(0, 1, 0, 0, 1, 32'h2, 32'h77, 0, 0, 0, 0, 0, wp(1));
        tbl[9] = mk(0, 0, 0, 1, 0, 32'h300, 0, 7, 1, 32'h2222, 0, 0,
                    wf(0, 1, 32'h300, 32'hCAFEF00D, 7));

        // Reset: all W outputs zero, no request, no stall.
        for (int i = 0; i < 2; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wf(0, 0, 0, 0, 0)));

        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Store acked after 3 wait cycles: 4 request cycles, 3 stalls/bubbles.
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 0, 0, 1, 32'h40, 32'h12345678, 0, 0, 0, 1, 1, wp(0)));
        step(mk(0, 1, 0, 0, 1, 32'h40, 32'h12345678, 0, 1, 32'h5555, 1, 0,
                wf(0, 0, 32'h40, 32'hCAFEF00D, 0)));

        // Load never acked: 15 stall cycles, then abort with request dropped.
        for (int i = 0; i < int'(TO); i++)
            step(mk(0, 1, 1, 1, 0, 32'h80, 0, 6, 0, 0, 1, 1, wp(0)));
        step(mk(0, 1, 1, 1, 0, 32'h80, 0, 6, 0, 0, 0, 0, wp(1)));
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wf(0, 0, 0, 32'hCAFEF00D, 0));
        step(nop);

        // Reset two cycles into WAIT abandons the access; a late ack is ignored.
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 1, 1, 0, 32'h90, 0, 8, 0, 0, 1, 1, wp(0)));
        step(mk(1, 1, 1, 1, 0, 32'h90, 0, 8, 0, 0, 0, 0, wf(0, 0, 0, 0, 0)));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3333, 0, 0, wf(0, 0, 0, 0, 0)));
        step(mk(0, 1, 1, 1, 0, 32'h100, 0, 1, 1, 32'h4444, 1, 0,
                wf(1, 1, 32'h100, 32'h4444, 1)));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, wf(0, 0, 0, 32'h4444, 0)));

        @(negedge clk);
        pop_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
